// File: rtl/util_arb_pkg.sv
// Shared arbiter types and the wrap-around round-robin pick used by the burst arbiter.
package util_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

    // Widest request vector rr_pick can scan; callers zero-extend narrower vectors.
    localparam int RR_MAX_REQ = 64;

    // Returns the first set bit of req at or after ptr, wrapping at num-1 back to 0.
    function automatic int rr_pick(
        input logic [RR_MAX_REQ-1:0] req,
        input int                    ptr,
        input int                    num
    );
        int   idx;
        int   pick;
        logic found;
        pick  = 0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            if (i < num) begin
                idx = ptr + i;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (!found && req[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/util_skid_buffer.sv
// Two-entry skid buffer: registered outputs, full throughput, ready independent of out_ready.
module util_skid_buffer
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] slot_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  push;
    logic                  pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = slot_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= in_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/decoupled_burst_arbiter.sv
// Round-robin N:1 burst arbiter: a grant is held until the granted requester's last beat is accepted.
// Define DECOUPLED_BURST_ARB_OUT_REG_EN to register the output through a 2-entry skid buffer.
module decoupled_burst_arbiter
    import util_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic [ID_W-1:0]               m_id,
    output logic                          busy
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]       rr_ptr_d;
    logic [ID_W-1:0]       gnt_id_q;
    logic [ID_W-1:0]       gnt_id_d;
    logic [ID_W-1:0]       rr_next_pick;
    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  in_burst;
    logic                  fwd_ready;
    logic                  last_accepted;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_data[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign sel_data      = req_data[gnt_id_q];
    assign sel_valid     = s_valid[gnt_id_q];
    assign sel_last      = s_last[gnt_id_q];
    assign in_burst      = (state_q == BURST);
    assign busy          = in_burst;
    assign last_accepted = in_burst && sel_valid && sel_last && fwd_ready;
    assign rr_next_pick  = ID_W'(rr_pick(RR_MAX_REQ'(s_valid), int'(rr_ptr_q), NUM_REQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    // Grant is latched in IDLE, so every burst pays exactly one bubble cycle.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (|s_valid) begin
                    gnt_id_d = rr_next_pick;
                    state_d  = BURST;
                end
            end
            BURST: begin
                if (last_accepted) begin
                    rr_ptr_d = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_ready = '0;
        if (in_burst) begin
            s_ready[gnt_id_q] = fwd_ready;
        end
    end

`ifdef DECOUPLED_BURST_ARB_OUT_REG_EN
    localparam int SKID_W = ID_W + 1 + DATA_WIDTH;

    logic              skid_in_ready;
    logic [SKID_W-1:0] skid_out;

    // The burst ends once its last beat is inside the skid, not when it drains.
    assign fwd_ready = skid_in_ready;

    util_skid_buffer #(
        .DATA_WIDTH(SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({gnt_id_q, sel_last, sel_data}),
        .in_valid  (in_burst && sel_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (m_valid),
        .out_ready (m_ready)
    );

    assign m_id   = skid_out[SKID_W-1 -: ID_W];
    assign m_last = skid_out[DATA_WIDTH];
    assign m_data = skid_out[DATA_WIDTH-1:0];
`else
    assign fwd_ready = m_ready;
    assign m_valid   = in_burst && sel_valid;
    assign m_last    = in_burst && sel_last;
    assign m_data    = in_burst ? sel_data : '0;
    assign m_id      = gnt_id_q;
`endif

endmodule

// File: tb/tb_decoupled_burst_arbiter.sv
// Directed bench for decoupled_burst_arbiter: queue-driven producers, a transaction-level
// ownership model checked every cycle, and literal checks of the accepted-beat log.
module tb_decoupled_burst_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [N*DW-1:0] s_data  = '0;
    logic [N-1:0]  s_valid = '0;
    logic [N-1:0]  s_last  = '0;
    logic [N-1:0]  s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic [IW-1:0] m_id;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW:0] beats [N][$];
    logic [N-1:0] hs = '0;
    int log_id[$];
    int log_data[$];
    int log_last[$];
    int log_cyc[$];

    // Model: owner is the requester holding the bus (-1 when free); loser has lowest priority.
    int owner    = -1;
    int loser    = N - 1;
    int shown_id = 0;

    decoupled_burst_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .m_id    (m_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    = -1;
            loser    = N - 1;
            shown_id = 0;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (owner < 0 && s_valid[(loser + k) % N]) begin
                    owner = (loser + k) % N;
                end
            end
            if (owner >= 0) begin
                shown_id = owner;
            end
        end else if (s_valid[owner] && m_ready && s_last[owner]) begin
            loser = owner;
            owner = -1;
        end
    end

    always @(negedge clk) begin : cmp
        logic [N-1:0] exp_ready;
        exp_ready = '0;
        if (owner >= 0) begin
            exp_ready[owner] = m_ready;
            check_output("m_valid", 64'(m_valid), 64'(s_valid[owner]));
            check_output("m_last",  64'(m_last),  64'(s_last[owner]));
            check_output("m_data",  64'(m_data),  64'(s_data[owner*DW +: DW]));
        end else begin
            check_output("m_valid", 64'(m_valid), 64'(0));
            check_output("m_last",  64'(m_last),  64'(0));
            check_output("m_data",  64'(m_data),  64'(0));
        end
        check_output("s_ready", 64'(s_ready), 64'(exp_ready));
        check_output("busy",    64'(busy),    64'(owner >= 0));
        check_output("m_id",    64'(m_id),    64'(shown_id));
        hs = s_valid & s_ready;
        if (!rst && m_valid && m_ready) begin
            log_id.push_back(int'(m_id));
            log_data.push_back(int'(m_data));
            log_last.push_back(int'(m_last));
            log_cyc.push_back(cyc);
        end
    end

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (beats[i].size() > 0) begin
                s_valid[i]            = 1'b1;
                s_last[i]             = beats[i][0][DW];
                s_data[i*DW +: DW]    = beats[i][0][DW-1:0];
            end else begin
                s_valid[i]            = 1'b0;
                s_last[i]             = 1'b0;
                s_data[i*DW +: DW]    = '0;
            end
        end
    endtask

    task automatic push_burst(input int r, input int base, input int len);
        for (int k = 0; k < len; k++) begin
            beats[r].push_back({k == len - 1, DW'(base + k)});
        end
    endtask

    // Advance one cycle: retire accepted beats, then present the next inputs.
    task automatic apply_stimulus(input logic mr);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && beats[i].size() > 0) begin
                void'(beats[i].pop_front());
            end
        end
        m_ready = mr;
        drive_inputs();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            beats[i].delete();
        end
        m_ready = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_log(input string name, input int idx, input int eid, input int edata,
                             input int elast, input int ecyc);
        if (idx >= log_id.size()) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: beat %0d never accepted, expected id %0d data %0h", name, idx, eid, edata);
        end else begin
            check_output({name, "_id"},   64'(log_id[idx]),   64'(eid));
            check_output({name, "_data"}, 64'(log_data[idx]), 64'(edata));
            check_output({name, "_last"}, 64'(log_last[idx]), 64'(elast));
            if (ecyc >= 0) begin
                check_output({name, "_cycle"}, 64'(log_cyc[idx]), 64'(ecyc));
            end
        end
    endtask

    initial begin
        int base;
        int t0;

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_inputs();
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1);
            @(negedge clk);
            check_output("idle_m_valid", 64'(m_valid), 64'(0));
            check_output("idle_busy",    64'(busy),    64'(0));
            check_output("idle_s_ready", 64'(s_ready), 64'(0));
        end

        // Single requester: req2 sends A0..A3
        apply_stimulus(1'b1);
        base = log_id.size();
        push_burst(2, 'hA0, 4);
        drive_inputs();
        t0 = cyc;
        repeat (5) apply_stimulus(1'b1);
        @(negedge clk);
        check_output("busy_after_last", 64'(busy), 64'(0));
        for (int k = 0; k < 4; k++) begin
            check_log("single_req", base + k, 2, 'hA0 + k, (k == 3) ? 1 : 0, t0 + 1 + k);
        end

        // Priority after req2 completes: req3 ahead of req0
        apply_stimulus(1'b1);
        base = log_id.size();
        push_burst(0, 'hB0, 1);
        push_burst(3, 'hB3, 1);
        drive_inputs();
        repeat (6) apply_stimulus(1'b1);
        check_log("rr_after2_first",  base,     3, 'hB3, 1, -1);
        check_log("rr_after2_second", base + 1, 0, 'hB0, 1, -1);

        // Round-robin with all four requesters streaming 2-beat bursts
        apply_reset();
        base = log_id.size();
        for (int i = 0; i < N; i++) begin
            push_burst(i, 'hC0 + i * 16, 2);
            push_burst(i, 'hC0 + i * 16 + 2, 2);
        end
        drive_inputs();
        t0 = cyc;
        repeat (28) apply_stimulus(1'b1);
        for (int j = 0; j < 8; j++) begin
            for (int b = 0; b < 2; b++) begin
                check_log("rr_order", base + 2 * j + b, j % 4, 'hC0 + (j % 4) * 16 + (j / 4) * 2 + b,
                          b, t0 + 1 + 3 * j + b);
            end
        end

        // Backpressure on req1 while req0/req3 wait
        apply_reset();
        push_burst(0, 'h90, 1);
        drive_inputs();
        repeat (4) apply_stimulus(1'b1);
        base = log_id.size();
        push_burst(1, 'hD0, 3);
        push_burst(0, 'hE0, 1);
        push_burst(3, 'hE3, 1);
        drive_inputs();
        t0 = cyc;
        for (int k = 0; k < 20; k++) begin
            apply_stimulus((k % 2) == 0);
        end
        check_log("bp_req1_beat0", base,     1, 'hD0, 0, t0 + 1);
        check_log("bp_req1_beat1", base + 1, 1, 'hD1, 0, t0 + 3);
        check_log("bp_req1_beat2", base + 2, 1, 'hD2, 1, t0 + 5);
        check_log("bp_next_grant", base + 3, 3, 'hE3, 1, -1);
        check_log("bp_then_req0",  base + 4, 0, 'hE0, 1, -1);

        // Back-to-back single-beat bursts from req0
        apply_reset();
        base = log_id.size();
        for (int k = 0; k < 6; k++) begin
            push_burst(0, 'hF0 + k, 1);
        end
        drive_inputs();
        t0 = cyc;
        repeat (14) apply_stimulus(1'b1);
        for (int k = 0; k < 6; k++) begin
            check_log("single_beat", base + k, 0, 'hF0 + k, 1, t0 + 1 + 2 * k);
        end
        check_output("single_beat_count", 64'(log_id.size() - base), 64'(6));

        // Reset in the middle of a 5-beat burst
        apply_reset();
        push_burst(1, 'h51, 1);
        drive_inputs();
        repeat (3) apply_stimulus(1'b1);
        base = log_id.size();
        push_burst(0, 'h60, 5);
        drive_inputs();
        t0 = cyc;
        repeat (2) apply_stimulus(1'b1);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            beats[i].delete();
        end
        drive_inputs();
        @(negedge clk);
        check_output("rst_m_valid", 64'(m_valid), 64'(0));
        check_output("rst_s_ready", 64'(s_ready), 64'(0));
        check_output("rst_m_id",    64'(m_id),    64'(0));
        check_output("rst_busy",    64'(busy),    64'(0));
        check_log("pre_reset_beat", base, 0, 'h60, 0, t0 + 1);
        check_output("pre_reset_count", 64'(log_id.size() - base), 64'(1));
        apply_stimulus(1'b1);
        rst = 1'b0;
        base = log_id.size();
        push_burst(1, 'h71, 1);
        push_burst(2, 'h72, 1);
        drive_inputs();
        repeat (6) apply_stimulus(1'b1);
        check_log("post_reset_first",  base,     1, 'h71, 1, -1);
        check_log("post_reset_second", base + 1, 2, 'h72, 1, -1);

        apply_stimulus(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
